// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage in-order pipeline.
// Holds one instruction from ID and computes a single-cycle ALU result, or
// runs a 32-step restoring divider for div/mod. It hands the packed result
// to MEM using the valid/allow_in handshake.
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ID_to_EX_valid,
  input  logic [151:0] to_EX_data,
  output logic         EX_allow_in,
  input  logic         MEM_allow_in,
  output logic         EX_to_MEM_valid,
  output logic [103:0] to_MEM_data
);

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  logic         ex_valid_r;
  logic [151:0] data_r;
  logic [1:0]   state_r;
  logic [4:0]   count_r;
  logic [31:0]  quo_r;
  logic [31:0]  rem_r;
  logic [31:0]  dsr_r;

  // Fields of the latched instruction
  logic [31:0] pc_s;
  logic [11:0] alu_op_s;
  logic [3:0]  div_op_s;
  logic [31:0] src1_s;
  logic [31:0] src2_s;
  logic [31:0] rkd_s;
  logic [7:0]  ctrl_s;

  assign pc_s     = data_r[151:120];
  assign alu_op_s = data_r[119:108];
  assign div_op_s = data_r[107:104];
  assign src1_s   = data_r[103:72];
  assign src2_s   = data_r[71:40];
  assign rkd_s    = data_r[39:8];
  assign ctrl_s   = data_r[7:0];

  // Handshake
  logic is_div_s;
  logic ready_go_s;
  logic handoff_s;

  assign is_div_s        = |div_op_s;
  assign ready_go_s      = ~is_div_s | (state_r == DIV_DONE);
  assign EX_allow_in     = ~ex_valid_r | (ready_go_s & MEM_allow_in);
  assign EX_to_MEM_valid = ex_valid_r & ready_go_s;
  assign handoff_s       = EX_to_MEM_valid & MEM_allow_in;

  // Signed divides work on magnitudes; signs are restored on the way out
  logic        div_signed_s;
  logic        quo_neg_s;
  logic        rem_neg_s;
  logic [31:0] src1_mag_s;
  logic [31:0] src2_mag_s;

  assign div_signed_s = div_op_s[0] | div_op_s[1];
  assign quo_neg_s    = div_signed_s & (src1_s[31] ^ src2_s[31]);
  assign rem_neg_s    = div_signed_s & src1_s[31];
  assign src1_mag_s   = (div_signed_s & src1_s[31]) ? (32'd0 - src1_s) : src1_s;
  assign src2_mag_s   = (div_signed_s & src2_s[31]) ? (32'd0 - src2_s) : src2_s;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The remainder stays below
  // the divisor, so bit 32 of the difference is a clean borrow flag.
  logic [32:0] partial_s;
  logic [32:0] diff_s;

  assign partial_s = {rem_r, quo_r[31]};
  assign diff_s    = partial_s - {1'b0, dsr_r};

  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] div_res_s;

  assign quo_fix_s = quo_neg_s ? (32'd0 - quo_r) : quo_r;
  assign rem_fix_s = rem_neg_s ? (32'd0 - rem_r) : rem_r;
  assign div_res_s = (div_op_s[0] | div_op_s[2]) ? quo_fix_s : rem_fix_s;

  // Single-cycle ALU; alu_op is one-hot, so the terms can simply be OR-ed
  logic [31:0] slt_s;
  logic [31:0] sltu_s;
  logic [31:0] sra_s;
  logic [31:0] alu_res_s;

  assign slt_s  = {31'd0, ($signed(src1_s) < $signed(src2_s))};
  assign sltu_s = {31'd0, (src1_s < src2_s)};
  assign sra_s  = $signed(src1_s) >>> src2_s[4:0];

  assign alu_res_s = ({32{alu_op_s[0]}}  & (src1_s + src2_s))
                   | ({32{alu_op_s[1]}}  & (src1_s - src2_s))
                   | ({32{alu_op_s[2]}}  & slt_s)
                   | ({32{alu_op_s[3]}}  & sltu_s)
                   | ({32{alu_op_s[4]}}  & (src1_s & src2_s))
                   | ({32{alu_op_s[5]}}  & ~(src1_s | src2_s))
                   | ({32{alu_op_s[6]}}  & (src1_s | src2_s))
                   | ({32{alu_op_s[7]}}  & (src1_s ^ src2_s))
                   | ({32{alu_op_s[8]}}  & (src1_s << src2_s[4:0]))
                   | ({32{alu_op_s[9]}}  & (src1_s >> src2_s[4:0]))
                   | ({32{alu_op_s[10]}} & sra_s)
                   | ({32{alu_op_s[11]}} & src2_s);

  logic [31:0] result_s;

  // Divider output overrides the ALU whenever a div_op bit is set
  always_comb begin
    result_s = 32'd0;
    if (is_div_s) begin
      result_s = div_res_s;
    end else begin
      result_s = alu_res_s;
    end
  end

  assign to_MEM_data = {pc_s, result_s, rkd_s, ctrl_s};

  // Stage occupancy: refill from ID whenever the stage can accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r <= 1'b0;
    end else if (EX_allow_in) begin
      ex_valid_r <= ID_to_EX_valid;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // Instruction register: capture only on an actual transfer, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 152'd0;
    end else if (ID_to_EX_valid & EX_allow_in) begin
      data_r <= to_EX_data;
    end else begin
      data_r <= data_r;
    end
  end

  // Divider sequencer: load, 32 restoring steps, then hold until hand-off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= DIV_IDLE;
      count_r <= 5'd0;
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dsr_r   <= 32'd0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (ex_valid_r & is_div_s) begin
            quo_r   <= src1_mag_s;
            rem_r   <= 32'd0;
            dsr_r   <= src2_mag_s;
            count_r <= 5'd0;
            state_r <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          quo_r   <= {quo_r[30:0], ~diff_s[32]};
          rem_r   <= diff_s[32] ? partial_s[31:0] : diff_s[31:0];
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (handoff_s) begin
            state_r <= DIV_IDLE;
          end
        end
        default: begin
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random and directed stimulus for ex_stage, checked every
// cycle against a behavioural model of the stage (occupancy, ready time,
// expected result bus) plus literal expectations on directed instructions.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ID_to_EX_valid = 1'b0;
  logic [151:0] to_EX_data = 152'd0;
  logic         EX_allow_in;
  logic         MEM_allow_in = 1'b1;
  logic         EX_to_MEM_valid;
  logic [103:0] to_MEM_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int handoffs = 0;
  bit rand_mem = 1'b0;

  // Model state: is an instruction in EX, which one, and from which cycle it may leave
  bit           m_occ = 1'b0;
  logic [151:0] m_cur = 152'd0;
  int           m_ready = 0;
  bit           exp_valid;
  bit           exp_allow;
  logic [31:0]  lit_map [logic [31:0]];

  ex_stage dut (
    .clk(clk),
    .reset(reset),
    .ID_to_EX_valid(ID_to_EX_valid),
    .to_EX_data(to_EX_data),
    .EX_allow_in(EX_allow_in),
    .MEM_allow_in(MEM_allow_in),
    .EX_to_MEM_valid(EX_to_MEM_valid),
    .to_MEM_data(to_MEM_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected alu_result computed straight from the instruction semantics
  function automatic logic [31:0] model_result(input logic [151:0] d);
    logic [11:0] aop;
    logic [3:0]  dop;
    logic [31:0] a, b, q, r;
    longint      sa, sb;
    int          sh;
    aop = d[119:108];
    dop = d[107:104];
    a   = d[103:72];
    b   = d[71:40];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b[4:0]);
    if (dop != 4'd0) begin
      if (dop[0] | dop[1]) begin
        if (b == 32'd0) begin
          q = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
          r = a;
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end
      end else begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
      end
      return (dop[0] | dop[2]) ? q : r;
    end
    case (aop)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return (sa < sb) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << sh;
      12'h200: return a >> sh;
      12'h400: return 32'(sa >>> sh);
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [151:0] mk(input logic [31:0] pc, input logic [11:0] aop,
                                      input logic [3:0] dop, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] rkd;
    logic [7:0]  lo;
    rkd = $urandom();
    lo  = 8'($urandom());
    return {pc, aop, dop, a, b, rkd, lo};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model to the next edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      chk("rst_allow_in", 104'(EX_allow_in), 104'd1);
      chk("rst_valid", 104'(EX_to_MEM_valid), 104'd0);
      chk("rst_bus", to_MEM_data, 104'd0);
      m_occ = 1'b0;
    end else begin
      exp_valid = m_occ && (cyc >= m_ready);
      exp_allow = !m_occ || (exp_valid && MEM_allow_in);
      chk("valid", 104'(EX_to_MEM_valid), 104'(exp_valid));
      chk("allow_in", 104'(EX_allow_in), 104'(exp_allow));
      if (exp_valid && EX_to_MEM_valid) begin
        chk("mem_bus", to_MEM_data,
            {m_cur[151:120], model_result(m_cur), m_cur[39:8], m_cur[7:0]});
        if (lit_map.exists(m_cur[151:120])) begin
          chk("lit_result", 104'(to_MEM_data[71:40]), 104'(lit_map[m_cur[151:120]]));
        end
      end
      if (exp_valid && MEM_allow_in) begin
        handoffs = handoffs + 1;
        if (lit_map.exists(m_cur[151:120])) lit_map.delete(m_cur[151:120]);
        m_occ = 1'b0;
      end
      if (exp_allow && ID_to_EX_valid) begin
        m_occ   = 1'b1;
        m_cur   = to_EX_data;
        m_ready = cyc + 1 + ((to_EX_data[107:104] != 4'd0) ? 33 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mem) MEM_allow_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [151:0] d);
    bit acc;
    int n;
    ID_to_EX_valid = 1'b1;
    to_EX_data = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = EX_allow_in;
      step();
      n = n + 1;
    end
    ID_to_EX_valid = 1'b0;
    chk("accept_bound", 104'(acc), 104'd1);
  endtask

  task automatic send_lit(input logic [151:0] d, input logic [31:0] lit);
    lit_map[d[151:120]] = lit;
    send(d);
  endtask

  task automatic wait_valid(output int n, output bit saw_allow);
    n = 0;
    saw_allow = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      if (EX_to_MEM_valid) break;
      if (EX_allow_in) saw_allow = 1'b1;
      n = n + 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_occ && n < 200) begin
      step();
      n = n + 1;
    end
    chk("drain_bound", 104'(m_occ), 104'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit sa;
    int h0;
    int c0;
    logic [103:0] held;
    int k;
    logic [11:0] aop;
    logic [3:0] dop;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_allow_in", 104'(EX_allow_in), 104'd1);
    chk("post_rst_valid", 104'(EX_to_MEM_valid), 104'd0);
    chk("post_rst_bus", to_MEM_data, 104'd0);
    step();

    // Back-to-back ALU stream
    h0 = handoffs;
    c0 = cyc;
    send_lit(mk(32'hD000_0000, 12'h001, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001), 32'h8000_0000);
    send_lit(mk(32'hD000_0004, 12'h002, 4'd0, 32'h0000_0005, 32'h0000_0007), 32'hFFFF_FFFE);
    send_lit(mk(32'hD000_0008, 12'h004, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001), 32'h0000_0001);
    send_lit(mk(32'hD000_000C, 12'h008, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001), 32'h0000_0000);
    send_lit(mk(32'hD000_0010, 12'h400, 4'd0, 32'h8000_0000, 32'h0000_0004), 32'hF800_0000);
    chk("b2b_cycles", 104'(cyc - c0), 104'd5);
    chk("b2b_handoffs", 104'(handoffs - h0), 104'd4);
    drain();

    // Divide latency and stall of ID
    send_lit(mk(32'hD000_0100, 12'h000, 4'b0001, 32'hFFFF_FFF9, 32'h0000_0002), 32'hFFFF_FFFD);
    wait_valid(n, sa);
    chk("div_latency", 104'(n), 104'd33);
    chk("div_allow_low", 104'(sa), 104'd0);
    step();
    send_lit(mk(32'hD000_0104, 12'h001, 4'b0010, 32'hFFFF_FFF9, 32'h0000_0002), 32'hFFFF_FFFF);
    wait_valid(n, sa);
    chk("mod_latency", 104'(n), 104'd33);
    step();

    // Corner divides, issued back to back
    send_lit(mk(32'hD000_0200, 12'h000, 4'b0100, 32'h0000_0005, 32'h0000_0000), 32'hFFFF_FFFF);
    send_lit(mk(32'hD000_0204, 12'h000, 4'b1000, 32'h0000_0005, 32'h0000_0000), 32'h0000_0005);
    send_lit(mk(32'hD000_0208, 12'h000, 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    send_lit(mk(32'hD000_020C, 12'h000, 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0000_0000);
    send_lit(mk(32'hD000_0210, 12'h000, 4'b0001, 32'hFFFF_FFFB, 32'h0000_0000), 32'h0000_0001);
    drain();

    // MEM stall while the divide result is ready
    MEM_allow_in = 1'b0;
    send_lit(mk(32'hD000_0300, 12'h000, 4'b0100, 32'd1000, 32'd7), 32'd142);
    wait_valid(n, sa);
    step();
    held = to_MEM_data;
    h0 = handoffs;
    repeat (10) begin
      step();
      chk("stall_hold", to_MEM_data, held);
      chk("stall_valid", 104'(EX_to_MEM_valid), 104'd1);
    end
    chk("stall_no_handoff", 104'(handoffs - h0), 104'd0);
    MEM_allow_in = 1'b1;
    send_lit(mk(32'hD000_0304, 12'h001, 4'd0, 32'd3, 32'd4), 32'd7);
    chk("stall_one_handoff", 104'(handoffs - h0), 104'd1);
    drain();
    chk("stall_total_handoffs", 104'(handoffs - h0), 104'd2);

    // Reset in the middle of a divide
    send(mk(32'hD000_0400, 12'h000, 4'b0100, 32'd1000, 32'd3));
    repeat (16) step();
    #2 reset = 1'b1;
    #1;
    chk("abort_allow_in", 104'(EX_allow_in), 104'd1);
    chk("abort_valid", 104'(EX_to_MEM_valid), 104'd0);
    chk("abort_bus", to_MEM_data, 104'd0);
    step();
    step();
    reset = 1'b0;
    send_lit(mk(32'hD000_0404, 12'h000, 4'b0100, 32'd100, 32'd7), 32'd14);
    wait_valid(n, sa);
    chk("after_rst_latency", 104'(n), 104'd33);
    step();
    drain();

    // Random traffic with random MEM back-pressure
    rand_mem = 1'b1;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 15);
      if (k < 12) begin
        aop = 12'd1 << k;
        dop = 4'd0;
      end else begin
        aop = 12'($urandom());
        dop = 4'd1 << (k - 12);
      end
      send(mk(32'h1000_0000 + 32'(i * 4), aop, dop, rnd_val(), rnd_val()));
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_mem = 1'b0;
    MEM_allow_in = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
